// File: rtl/ofs_plat_hssi_multi_channel_stats.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : ofs_plat_hssi_multi_channel_stats
// Purpose : Per-channel HSSI AXI-S traffic statistics with saturating counters
//           and a single-outstanding CSR read port.
// Revision: 1.0 - initial release
// ============================================================================
module ofs_plat_hssi_multi_channel_stats #(
  parameter int NUM_CHANNELS  = 4,
  parameter int TDATA_WIDTH   = 64,
  parameter int CNT_WIDTH     = 32,
  parameter int CLEAR_ON_READ = 0
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic [NUM_CHANNELS-1:0]                 rx_tvalid,
  input  logic [NUM_CHANNELS-1:0]                 rx_tlast,
  input  logic [NUM_CHANNELS*TDATA_WIDTH/8-1:0]   rx_tkeep,
  input  logic [NUM_CHANNELS-1:0]                 tx_tvalid,
  input  logic [NUM_CHANNELS-1:0]                 tx_tready,
  input  logic [NUM_CHANNELS-1:0]                 tx_tlast,
  input  logic [NUM_CHANNELS*TDATA_WIDTH/8-1:0]   tx_tkeep,
  input  logic [NUM_CHANNELS-1:0]                 fc_pause,
  input  logic                                    rd_req,
  input  logic [(NUM_CHANNELS > 1 ? $clog2(NUM_CHANNELS) : 1)-1:0] rd_chan,
  input  logic [2:0]                              rd_sel,
  input  logic                                    clr_all,
  output logic                                    rd_ack,
  output logic [CNT_WIDTH-1:0]                    rd_data
);

  localparam int c_KEEP_W        = TDATA_WIDTH / 8;
  localparam int c_CHAN_W        = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam int c_NUM_SEL       = 6;
  localparam int c_SEL_RX_PKTS   = 0;
  localparam int c_SEL_RX_BYTES  = 1;
  localparam int c_SEL_TX_PKTS   = 2;
  localparam int c_SEL_TX_BYTES  = 3;
  localparam int c_SEL_PAUSE     = 4;
  localparam int c_SEL_FRAME_ERR = 5;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_IN_PKT = 1'b1
  } rx_state_t;

  rx_state_t            r_rx_state     [NUM_CHANNELS];
  rx_state_t            w_rx_state_nxt [NUM_CHANNELS];
  logic [CNT_WIDTH-1:0] r_cnt          [NUM_CHANNELS][c_NUM_SEL];
  logic [CNT_WIDTH-1:0] w_inc          [NUM_CHANNELS][c_NUM_SEL];
  logic [CNT_WIDTH-1:0] w_rd_val;
  logic                 r_rd_ack;
  logic [CNT_WIDTH-1:0] r_rd_data;

  function automatic logic [CNT_WIDTH-1:0] popcount(input logic [c_KEEP_W-1:0] keep);
    logic [CNT_WIDTH-1:0] n;
    n = '0;
    for (int i = 0; i < c_KEEP_W; i++) n = n + CNT_WIDTH'(keep[i]);
    return n;
  endfunction

  function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] a,
                                                   input logic [CNT_WIDTH-1:0] b);
    logic [CNT_WIDTH:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[CNT_WIDTH] ? '1 : sum[CNT_WIDTH-1:0];
  endfunction

  // Per-cycle increments and RX framing next state for every channel
  always_comb begin
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      w_rx_state_nxt[c] = r_rx_state[c];
      for (int s = 0; s < c_NUM_SEL; s++) w_inc[c][s] = '0;

      if (rx_tvalid[c]) begin
        w_inc[c][c_SEL_RX_BYTES] = popcount(rx_tkeep[c*c_KEEP_W +: c_KEEP_W]);
        if (rx_tlast[c]) w_inc[c][c_SEL_RX_PKTS] = CNT_WIDTH'(1);
        if ((rx_tkeep[c*c_KEEP_W +: c_KEEP_W] == '0) ||
            ((r_rx_state[c] == ST_IN_PKT) && !rx_tlast[c] &&
             (rx_tkeep[c*c_KEEP_W +: c_KEEP_W] != '1)))
          w_inc[c][c_SEL_FRAME_ERR] = CNT_WIDTH'(1);
        if ((r_rx_state[c] == ST_IDLE) && !rx_tlast[c])
          w_rx_state_nxt[c] = ST_IN_PKT;
        else if ((r_rx_state[c] == ST_IN_PKT) && rx_tlast[c])
          w_rx_state_nxt[c] = ST_IDLE;
      end

      if (tx_tvalid[c] && tx_tready[c]) begin
        w_inc[c][c_SEL_TX_BYTES] = popcount(tx_tkeep[c*c_KEEP_W +: c_KEEP_W]);
        if (tx_tlast[c]) w_inc[c][c_SEL_TX_PKTS] = CNT_WIDTH'(1);
      end

      if (fc_pause[c]) w_inc[c][c_SEL_PAUSE] = CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (reset) r_rx_state[c] <= ST_IDLE;
      else       r_rx_state[c] <= w_rx_state_nxt[c];
    end
  end

  // Clear-on-read keeps the read cycle's own increment so no event is lost
  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      for (int s = 0; s < c_NUM_SEL; s++) begin
        if (reset || clr_all)
          r_cnt[c][s] <= '0;
        else if ((CLEAR_ON_READ != 0) && rd_req &&
                 (rd_chan == c_CHAN_W'(c)) && (rd_sel == 3'(s)))
          r_cnt[c][s] <= w_inc[c][s];
        else
          r_cnt[c][s] <= sat_add(r_cnt[c][s], w_inc[c][s]);
      end
    end
  end

  // Reserved selectors and out-of-range channels match nothing and read 0
  always_comb begin
    w_rd_val = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      for (int s = 0; s < c_NUM_SEL; s++) begin
        if ((rd_chan == c_CHAN_W'(c)) && (rd_sel == 3'(s))) w_rd_val = r_cnt[c][s];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_ack  <= 1'b0;
      r_rd_data <= '0;
    end else begin
      r_rd_ack <= rd_req;
      if (rd_req) r_rd_data <= w_rd_val;
    end
  end

  assign rd_ack  = r_rd_ack;
  assign rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: tb/tb_ofs_plat_hssi_multi_channel_stats.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_ofs_plat_hssi_multi_channel_stats
// Purpose : Scoreboard bench; dut_a uses default parameters, dut_b uses
//           16-bit counters with clear-on-read. Both see the same traffic.
// Revision: 1.0 - initial release
// ============================================================================
module tb_ofs_plat_hssi_multi_channel_stats;

  localparam int NCH = 4;
  localparam int KW  = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset = 1'b1;
  logic [NCH-1:0]  rx_tvalid = '0, rx_tlast = '0;
  logic [NCH-1:0]  tx_tvalid = '0, tx_tready = '0, tx_tlast = '0, fc_pause = '0;
  logic [NCH*KW-1:0] rx_tkeep = '0, tx_tkeep = '0;
  logic            rd_req_a = 1'b0, rd_req_b = 1'b0, clr_all = 1'b0;
  logic [1:0]      rd_chan = '0;
  logic [2:0]      rd_sel = '0;
  logic            rd_ack_a, rd_ack_b;
  logic [31:0]     rd_data_a;
  logic [15:0]     rd_data_b;

  ofs_plat_hssi_multi_channel_stats #(
    .NUM_CHANNELS(NCH), .TDATA_WIDTH(64), .CNT_WIDTH(32), .CLEAR_ON_READ(0)
  ) dut_a (
    .clk(clk), .reset(reset),
    .rx_tvalid(rx_tvalid), .rx_tlast(rx_tlast), .rx_tkeep(rx_tkeep),
    .tx_tvalid(tx_tvalid), .tx_tready(tx_tready), .tx_tlast(tx_tlast), .tx_tkeep(tx_tkeep),
    .fc_pause(fc_pause), .rd_req(rd_req_a), .rd_chan(rd_chan), .rd_sel(rd_sel),
    .clr_all(clr_all), .rd_ack(rd_ack_a), .rd_data(rd_data_a)
  );

  ofs_plat_hssi_multi_channel_stats #(
    .NUM_CHANNELS(NCH), .TDATA_WIDTH(64), .CNT_WIDTH(16), .CLEAR_ON_READ(1)
  ) dut_b (
    .clk(clk), .reset(reset),
    .rx_tvalid(rx_tvalid), .rx_tlast(rx_tlast), .rx_tkeep(rx_tkeep),
    .tx_tvalid(tx_tvalid), .tx_tready(tx_tready), .tx_tlast(tx_tlast), .tx_tkeep(tx_tkeep),
    .fc_pause(fc_pause), .rd_req(rd_req_b), .rd_chan(rd_chan), .rd_sel(rd_sel),
    .clr_all(clr_all), .rd_ack(rd_ack_b), .rd_data(rd_data_b)
  );

  typedef struct {
    logic [31:0] data;
    int          cyc;
    string       name;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t e_a, e_b;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitors: every rd_ack must match the oldest expectation, on its cycle
  always @(negedge clk) begin
    if (rd_ack_a) begin
      checks++;
      if (q_a.size() == 0) begin
        errors++;
        $display("FAIL spurious_ack_a: rd_ack=1 rd_data=%0h, no read outstanding", rd_data_a);
      end else begin
        e_a = q_a.pop_front();
        if (rd_data_a !== e_a.data || cyc != e_a.cyc) begin
          errors++;
          $display("FAIL %s (dut_a): rd_data=%0h at cycle %0d, expected %0h at cycle %0d",
                   e_a.name, rd_data_a, cyc, e_a.data, e_a.cyc);
        end
      end
    end else if (q_a.size() > 0 && q_a[0].cyc <= cyc) begin
      checks++;
      errors++;
      e_a = q_a.pop_front();
      $display("FAIL %s (dut_a): rd_ack=0 at cycle %0d, expected 1", e_a.name, cyc);
    end
  end

  always @(negedge clk) begin
    if (rd_ack_b) begin
      checks++;
      if (q_b.size() == 0) begin
        errors++;
        $display("FAIL spurious_ack_b: rd_ack=1 rd_data=%0h, no read outstanding", rd_data_b);
      end else begin
        e_b = q_b.pop_front();
        if (rd_data_b !== e_b.data[15:0] || cyc != e_b.cyc) begin
          errors++;
          $display("FAIL %s (dut_b): rd_data=%0h at cycle %0d, expected %0h at cycle %0d",
                   e_b.name, rd_data_b, cyc, e_b.data[15:0], e_b.cyc);
        end
      end
    end else if (q_b.size() > 0 && q_b[0].cyc <= cyc) begin
      checks++;
      errors++;
      e_b = q_b.pop_front();
      $display("FAIL %s (dut_b): rd_ack=0 at cycle %0d, expected 1", e_b.name, cyc);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Queue the expectation and raise rd_req for one cycle
  task automatic arm_read(input bit b, input int ch, input int sel,
                          input logic [31:0] exp, input string nm);
    exp_t e;
    e.data = exp;
    e.cyc  = cyc + 1;
    e.name = nm;
    rd_chan = 2'(ch);
    rd_sel  = 3'(sel);
    if (b) begin rd_req_b = 1'b1; q_b.push_back(e); end
    else   begin rd_req_a = 1'b1; q_a.push_back(e); end
  endtask

  task automatic rd(input bit b, input int ch, input int sel,
                    input logic [31:0] exp, input string nm);
    arm_read(b, ch, sel, exp, nm);
    step();
    rd_req_a = 1'b0;
    rd_req_b = 1'b0;
  endtask

  task automatic rx_beat(input int ch, input logic [7:0] keep, input bit last);
    rx_tvalid[ch]         = 1'b1;
    rx_tkeep[ch*KW +: KW] = keep;
    rx_tlast[ch]          = last;
    step();
    rx_tvalid = '0;
    rx_tkeep  = '0;
    rx_tlast  = '0;
  endtask

  task automatic do_clr();
    clr_all = 1'b1;
    step();
    clr_all = 1'b0;
  endtask

  bit rdy[4] = '{1'b1, 1'b0, 1'b1, 1'b1};

  initial begin
    // Reset state
    repeat (3) step();
    chk("reset_ack_a", {31'd0, rd_ack_a}, 32'd0);
    chk("reset_data_a", rd_data_a, 32'd0);
    chk("reset_data_b", {16'd0, rd_data_b}, 32'd0);
    reset = 1'b0;
    step();

    // All selectors on channel 0 read 0, back to back; reserved selectors too
    for (int s = 0; s < 6; s++) rd(1'b0, 0, s, 32'd0, $sformatf("reset_ch0_sel%0d", s));
    rd(1'b0, 0, 6, 32'd0, "reserved_sel6");
    rd(1'b1, 0, 7, 32'd0, "reserved_sel7");

    // Channel 1 RX: three beats FF, FF, 0F
    rx_beat(1, 8'hFF, 1'b0);
    rx_beat(1, 8'hFF, 1'b0);
    rx_beat(1, 8'h0F, 1'b1);
    rd(1'b0, 1, 0, 32'd1,  "ch1_rx_pkts");
    rd(1'b0, 1, 1, 32'd20, "ch1_rx_bytes");
    rd(1'b0, 1, 5, 32'd0,  "ch1_rx_frame_err");
    rd(1'b0, 0, 1, 32'd0,  "ch0_rx_bytes_idle");
    rd(1'b0, 2, 1, 32'd0,  "ch2_rx_bytes_idle");
    rd(1'b0, 3, 0, 32'd0,  "ch3_rx_pkts_idle");
    do_clr();

    // Channel 2 TX with a stalled beat; channel 1 one sparse-keep beat
    for (int i = 0; i < 4; i++) begin
      tx_tvalid[2]   = 1'b1;
      tx_tready[2]   = rdy[i];
      tx_tkeep[23:16] = 8'hFF;
      tx_tlast[2]    = (i == 3);
      if (i == 0) begin
        tx_tvalid[1] = 1'b1;
        tx_tready[1] = 1'b1;
        tx_tkeep[15:8] = 8'hA5;
        tx_tlast[1]  = 1'b1;
      end
      step();
      tx_tvalid = '0; tx_tready = '0; tx_tkeep = '0; tx_tlast = '0;
    end
    rd(1'b0, 2, 3, 32'd24, "ch2_tx_bytes");
    step();
    chk("rd_ack_falls", {31'd0, rd_ack_a}, 32'd0);
    chk("rd_data_holds", rd_data_a, 32'd24);
    rd(1'b0, 2, 2, 32'd1, "ch2_tx_pkts");
    rd(1'b0, 1, 3, 32'd4, "ch1_tx_bytes_sparse");
    rd(1'b0, 1, 2, 32'd1, "ch1_tx_pkts");
    rd(1'b0, 2, 0, 32'd0, "ch2_rx_pkts_idle");
    rd(1'b1, 2, 3, 32'd24, "cor_ch2_tx_bytes");
    rd(1'b1, 2, 3, 32'd0,  "cor_ch2_tx_bytes_cleared");
    do_clr();

    // Channel 3 framing errors
    rx_beat(3, 8'h0F, 1'b1);
    rx_beat(3, 8'hFF, 1'b0);
    rx_beat(3, 8'h0F, 1'b0);
    rx_beat(3, 8'h00, 1'b1);
    rd(1'b0, 3, 5, 32'd2,  "ch3_frame_err");
    rd(1'b0, 3, 0, 32'd2,  "ch3_rx_pkts");
    rd(1'b0, 3, 1, 32'd16, "ch3_rx_bytes");
    rd(1'b1, 3, 5, 32'd2,  "cor_ch3_frame_err");

    // clr_all with a same-cycle read and a same-cycle beat
    rx_tvalid[3] = 1'b1; rx_tkeep[31:24] = 8'hFF; rx_tlast[3] = 1'b1;
    clr_all = 1'b1;
    rd(1'b0, 3, 5, 32'd2, "clr_read_pre_value");
    clr_all = 1'b0; rx_tvalid = '0; rx_tkeep = '0; rx_tlast = '0;
    rd(1'b0, 3, 5, 32'd0, "clr_frame_err_zero");
    rd(1'b0, 3, 0, 32'd0, "clr_discards_pkt");
    rd(1'b0, 3, 1, 32'd0, "clr_discards_bytes");

    // clr_all leaves the framing FSM in IN_PKT
    rx_beat(3, 8'hFF, 1'b0);
    do_clr();
    rx_beat(3, 8'h0F, 1'b0);
    rd(1'b0, 3, 5, 32'd1, "clr_keeps_fsm");

    // Reset mid-packet returns the FSM to IDLE
    reset = 1'b1;
    step();
    reset = 1'b0;
    rx_beat(3, 8'h0F, 1'b0);
    rd(1'b0, 3, 5, 32'd0, "reset_fsm_idle");
    rx_beat(3, 8'h00, 1'b1);
    rd(1'b0, 3, 5, 32'd1, "zero_keep_err");
    rd(1'b0, 3, 1, 32'd4, "post_reset_bytes");

    // Clear-on-read pause counting on channel 0
    do_clr();
    fc_pause[0] = 1'b1;
    repeat (3) step();
    rd(1'b1, 0, 4, 32'd3, "cor_pause_first");
    repeat (4) step();
    rd(1'b1, 0, 4, 32'd5, "cor_pause_second");
    fc_pause = '0;
    rd(1'b0, 0, 4, 32'd9, "pause_no_cor");

    // Saturation of the 16-bit byte counter
    do_clr();
    repeat (8200) rx_beat(0, 8'hFF, 1'b1);
    rd(1'b0, 0, 1, 32'd65600, "wide_rx_bytes");
    rd(1'b0, 0, 0, 32'd8200,  "wide_rx_pkts");
    repeat (10) rx_beat(0, 8'hFF, 1'b1);
    rd(1'b0, 0, 1, 32'd65680,    "wide_rx_bytes_more");
    rd(1'b1, 0, 1, 32'h0000FFFF, "sat_rx_bytes");
    rd(1'b1, 0, 0, 32'd8210,     "narrow_rx_pkts");

    repeat (3) step();
    chk("queues_drained", q_a.size() + q_b.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
